// File: rtl/frame_buffer_serdes_pkg.sv
// Shared types for the ping-pong frame buffer.
package frame_buffer_serdes_pkg;

  // Lifecycle of one frame bank.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_e;

endpackage

// File: rtl/frame_bank.sv
// One frame bank: sample storage, per-frame len/rev latches and fill state.
module frame_bank
  import frame_buffer_serdes_pkg::*;
#(
  parameter  int unsigned BIT_WIDTH = 32,
  parameter  int unsigned N_SAMPLES = 8,
  localparam int unsigned IDX_W     = $clog2(N_SAMPLES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [BIT_WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0]     cfg_len,
  input  logic                 cfg_rev,
  input  logic                 rd_clear,
  input  logic [IDX_W-1:0]     rd_idx,
  output bank_state_e          state,
  output logic [IDX_W-1:0]     len,
  output logic                 wr_last_c,
  output logic [BIT_WIDTH-1:0] rd_data_c
);

  bank_state_e          state_q, state_d;
  logic [IDX_W-1:0]     len_q;
  logic                 rev_q;
  logic [IDX_W-1:0]     eff_len_c;
  logic [IDX_W-1:0]     rd_addr_c;
  logic [BIT_WIDTH-1:0] mem [N_SAMPLES];

  // An empty bank takes its length from the live config on its first write.
  always_comb begin
    eff_len_c = (state_q == EMPTY) ? cfg_len : len_q;
    wr_last_c = (wr_idx == eff_len_c);
    rd_addr_c = rev_q ? IDX_W'(len_q - rd_idx) : rd_idx;
    rd_data_c = mem[rd_addr_c];
    state     = state_q;
    len       = len_q;
  end

  // Bank state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next-state: fill on writes, release once the reader takes the last word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (wr_en) state_d = wr_last_c ? FULL : FILLING;
      FILLING: if (wr_en && wr_last_c) state_d = FULL;
      FULL:    if (rd_clear) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Latch frame length and order on the first word of a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q <= '0;
      rev_q <= 1'b0;
    end else if (wr_en && (state_q == EMPTY)) begin
      len_q <= cfg_len;
      rev_q <= cfg_rev;
    end
  end

  // Sample storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

endmodule

// File: rtl/frame_buffer_serdes.sv
// Ping-pong frame buffer: fills one bank from recv while the other drains to send.
module frame_buffer_serdes
  import frame_buffer_serdes_pkg::*;
#(
  parameter  int unsigned BIT_WIDTH = 32,
  parameter  int unsigned N_SAMPLES = 8,
  localparam int unsigned IDX_W     = $clog2(N_SAMPLES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IDX_W-1:0]     cfg_len,
  input  logic                 cfg_rev,
  input  logic [BIT_WIDTH-1:0] recv_msg,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  output logic [BIT_WIDTH-1:0] send_msg,
  output logic                 send_val,
  input  logic                 send_rdy,
  output logic                 send_last
);

  logic                 wb_q, rb_q;
  logic [IDX_W-1:0]     widx_q, ridx_q;
  logic                 in_fire_c, out_fire_c;
  logic                 wr_last_c, rd_last_c;
  logic [1:0]           bank_wr_en, bank_rd_clear;
  bank_state_e          bank_state     [2];
  logic [IDX_W-1:0]     bank_len       [2];
  logic                 bank_wr_last_c [2];
  logic [BIT_WIDTH-1:0] bank_rd_data_c [2];

  // Two banks sharing the write/read indices; enables steer to wb/rb.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    frame_bank #(
      .BIT_WIDTH (BIT_WIDTH),
      .N_SAMPLES (N_SAMPLES)
    ) u_bank (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (bank_wr_en[b]),
      .wr_idx    (widx_q),
      .wr_data   (recv_msg),
      .cfg_len   (cfg_len),
      .cfg_rev   (cfg_rev),
      .rd_clear  (bank_rd_clear[b]),
      .rd_idx    (ridx_q),
      .state     (bank_state[b]),
      .len       (bank_len[b]),
      .wr_last_c (bank_wr_last_c[b]),
      .rd_data_c (bank_rd_data_c[b])
    );
  end

  // Handshakes depend only on registered bank state.
  always_comb begin
    recv_rdy      = (bank_state[wb_q] != FULL);
    send_val      = (bank_state[rb_q] == FULL);
    wr_last_c     = bank_wr_last_c[wb_q];
    rd_last_c     = (ridx_q == bank_len[rb_q]);
    in_fire_c     = recv_val & recv_rdy;
    out_fire_c    = send_val & send_rdy;
    send_msg      = send_val ? bank_rd_data_c[rb_q] : '0;
    send_last     = send_val & rd_last_c;
    bank_wr_en    = '0;
    bank_rd_clear = '0;
    bank_wr_en[wb_q]    = in_fire_c;
    bank_rd_clear[rb_q] = out_fire_c & rd_last_c;
  end

  // Write-side pointer: advance within a frame, hop banks on the last word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_q   <= 1'b0;
      widx_q <= '0;
    end else if (in_fire_c) begin
      if (wr_last_c) begin
        wb_q   <= ~wb_q;
        widx_q <= '0;
      end else begin
        widx_q <= widx_q + IDX_W'(1);
      end
    end
  end

  // Read-side pointer: same scheme against the read bank's latched len.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rb_q   <= 1'b0;
      ridx_q <= '0;
    end else if (out_fire_c) begin
      if (rd_last_c) begin
        rb_q   <= ~rb_q;
        ridx_q <= '0;
      end else begin
        ridx_q <= ridx_q + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_frame_buffer_serdes.sv
// Directed bench for frame_buffer_serdes.
module tb_frame_buffer_serdes;

  localparam int unsigned BW = 32;
  localparam int unsigned NS = 8;
  localparam int unsigned IW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [IW-1:0] cfg_len;
  logic          cfg_rev;
  logic [BW-1:0] recv_msg;
  logic          recv_val;
  logic          recv_rdy;
  logic [BW-1:0] send_msg;
  logic          send_val;
  logic          send_rdy;
  logic          send_last;

  int n_cmp = 0;
  int n_err = 0;

  frame_buffer_serdes #(.BIT_WIDTH(BW), .N_SAMPLES(NS)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_len   (cfg_len),
    .cfg_rev   (cfg_rev),
    .recv_msg  (recv_msg),
    .recv_val  (recv_val),
    .recv_rdy  (recv_rdy),
    .send_msg  (send_msg),
    .send_val  (send_val),
    .send_rdy  (send_rdy),
    .send_last (send_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input int m, input logic l);
    chk($sformatf("%s.val", tag), 32'(send_val), 32'(v));
    chk($sformatf("%s.msg", tag), send_msg, 32'(m));
    chk($sformatf("%s.last", tag), 32'(send_last), 32'(l));
  endtask

  task automatic chk_rdy(input string tag, input logic r);
    chk($sformatf("%s.rdy", tag), 32'(recv_rdy), 32'(r));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic v;
    reset    = 1'b0;
    cfg_len  = 3'(0);
    cfg_rev  = 1'b0;
    recv_msg = '0;
    recv_val = 1'b0;
    send_rdy = 1'b0;
    #12;
    chk_rdy("reset", 1'b1);
    chk_out("reset", 1'b0, 0, 1'b0);
    reset = 1'b1;

    // Full-length in-order frame.
    cfg_len  = 3'(7);
    send_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      recv_val = 1'b1;
      recv_msg = 32'(i);
      chk_rdy("t1_in", 1'b1);
      chk_out("t1_in", 1'b0, 0, 1'b0);
      tick();
    end
    recv_val = 1'b0;
    for (int j = 0; j < 8; j++) begin
      chk_out($sformatf("t1_out%0d", j), 1'b1, j, j == 7);
      tick();
    end
    chk_out("t1_idle", 1'b0, 0, 1'b0);

    // Short reversed frame.
    cfg_len = 3'(3);
    cfg_rev = 1'b1;
    for (int i = 0; i < 4; i++) begin
      recv_val = 1'b1;
      recv_msg = 32'(10 + i);
      tick();
    end
    recv_val = 1'b0;
    cfg_rev  = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk_out($sformatf("t2_out%0d", j), 1'b1, 13 - j, j == 3);
      tick();
    end
    chk_out("t2_idle", 1'b0, 0, 1'b0);

    // Four back-to-back frames, full throughput.
    cfg_len = 3'(7);
    for (int c = 0; c <= 40; c++) begin
      recv_val = (c < 32);
      recv_msg = (c < 32) ? 32'(100 + c) : '0;
      if (c < 32) chk_rdy($sformatf("t3_c%0d", c), 1'b1);
      v = (c >= 8) && (c < 40);
      chk_out($sformatf("t3_c%0d", c), v, v ? 100 + c - 8 : 0, v && ((c - 8) % 8 == 7));
      tick();
    end

    // Back-pressure with both banks full.
    send_rdy = 1'b0;
    for (int c = 0; c < 16; c++) begin
      recv_val = 1'b1;
      recv_msg = 32'(200 + c);
      chk_rdy($sformatf("t4_fill%0d", c), 1'b1);
      chk_out($sformatf("t4_fill%0d", c), c >= 8, c >= 8 ? 200 : 0, 1'b0);
      tick();
    end
    for (int s = 0; s < 3; s++) begin
      recv_val = 1'b1;
      recv_msg = 32'(216);
      chk_rdy($sformatf("t4_stall%0d", s), 1'b0);
      chk_out($sformatf("t4_stall%0d", s), 1'b1, 200, 1'b0);
      tick();
    end
    send_rdy = 1'b1;
    for (int d = 0; d < 24; d++) begin
      recv_val = (d < 16);
      recv_msg = (d < 8) ? 32'(216) : 32'(216 + d - 8);
      chk_rdy($sformatf("t4_d%0d", d), d >= 8);
      chk_out($sformatf("t4_d%0d", d), 1'b1, 200 + d, d % 8 == 7);
      tick();
    end
    recv_val = 1'b0;
    chk_rdy("t4_idle", 1'b1);
    chk_out("t4_idle", 1'b0, 0, 1'b0);

    // Single-word frames.
    cfg_len = 3'(0);
    for (int c = 0; c < 4; c++) begin
      recv_val = (c < 3);
      recv_msg = 32'(30 + c);
      chk_rdy($sformatf("t5a_c%0d", c), 1'b1);
      chk_out($sformatf("t5a_c%0d", c), c >= 1, c >= 1 ? 30 + c - 1 : 0, c >= 1);
      tick();
    end
    recv_val = 1'b0;
    chk_out("t5a_idle", 1'b0, 0, 1'b0);

    // Length change mid-frame only affects the next frame.
    for (int c = 0; c <= 18; c++) begin
      cfg_len  = (c < 4) ? 3'(7) : 3'(1);
      recv_val = (c < 10);
      recv_msg = (c < 8) ? 32'(40 + c) : 32'(50 + c - 8);
      chk_rdy($sformatf("t5b_c%0d", c), !((c >= 10) && (c <= 15)));
      if (c < 8)       chk_out($sformatf("t5b_c%0d", c), 1'b0, 0, 1'b0);
      else if (c < 16) chk_out($sformatf("t5b_c%0d", c), 1'b1, 40 + c - 8, c == 15);
      else if (c < 18) chk_out($sformatf("t5b_c%0d", c), 1'b1, 50 + c - 16, c == 17);
      else             chk_out($sformatf("t5b_c%0d", c), 1'b0, 0, 1'b0);
      tick();
    end
    recv_val = 1'b0;

    // Reset mid-fill.
    cfg_len = 3'(7);
    for (int c = 0; c < 5; c++) begin
      recv_val = 1'b1;
      recv_msg = 32'(60 + c);
      tick();
    end
    recv_val = 1'b0;
    reset    = 1'b0;
    #1;
    chk_rdy("t6_rst_fill", 1'b1);
    chk_out("t6_rst_fill", 1'b0, 0, 1'b0);
    tick();
    reset = 1'b1;

    // Reset mid-drain.
    send_rdy = 1'b0;
    for (int c = 0; c < 8; c++) begin
      recv_val = 1'b1;
      recv_msg = 32'(70 + c);
      tick();
    end
    recv_val = 1'b0;
    send_rdy = 1'b1;
    for (int j = 0; j < 3; j++) begin
      chk_out($sformatf("t6_drain%0d", j), 1'b1, 70 + j, 1'b0);
      tick();
    end
    reset = 1'b0;
    #1;
    chk_rdy("t6_rst_drain", 1'b1);
    chk_out("t6_rst_drain", 1'b0, 0, 1'b0);
    tick();
    reset = 1'b1;

    // Fresh frame after reset carries no stale words.
    for (int i = 0; i < 8; i++) begin
      recv_val = 1'b1;
      recv_msg = 32'(20 + i);
      chk_out($sformatf("t6_in%0d", i), 1'b0, 0, 1'b0);
      tick();
    end
    recv_val = 1'b0;
    for (int j = 0; j < 8; j++) begin
      chk_out($sformatf("t6_out%0d", j), 1'b1, 20 + j, j == 7);
      tick();
    end
    chk_out("t6_idle", 1'b0, 0, 1'b0);
    chk_rdy("t6_idle", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
